// File: rtl/pipe_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_frame_sequencer
// Description : Per-frame controller placed in front of the pipe outline
//               drawer. Each frame tick runs three passes over the pipes:
//               erase every visible pipe at its old position, scroll all
//               pipes left (recycling off-screen pipes with a pseudo-random
//               gap height), then redraw every visible pipe.
// Ports       : clk           - system clock
//               reset         - synchronous, active-high reset
//               frame_tick    - one-cycle pulse that starts a frame update
//               drawer_done   - completion strobe from the pipe drawer
//               drawer_enable - start/hold request to the pipe drawer
//               pipe_x/pipe_y - right edge / y reference of selected pipe
//               color         - 0 = erase (black), 1 = draw (white)
//               busy          - high whenever a frame update is running
//               frame_done    - one-cycle pulse when the update completes
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_frame_sequencer #(
   parameter int NUM_PIPES = 3,
   parameter int SPACING   = 240,
   parameter int START_X   = 640,
   parameter int SPEED     = 2,
   parameter int Y_INIT    = 300,
   parameter int Y_MIN     = 200,
   parameter int PIPE_W    = 70,
   parameter int SCREEN_W  = 640
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        drawer_done,
   output logic        drawer_enable,
   output logic [10:0] pipe_x,
   output logic [10:0] pipe_y,
   output logic        color,
   output logic        busy,
   output logic        frame_done
);

   localparam int                 c_IDX_W     = $clog2(NUM_PIPES);
   localparam logic [c_IDX_W-1:0] c_LAST      = c_IDX_W'(NUM_PIPES - 1);
   localparam logic [10:0]        c_SPEED     = 11'(SPEED);
   localparam logic [10:0]        c_WRAP_ADD  = 11'(NUM_PIPES * SPACING);
   localparam logic [10:0]        c_Y_MIN     = 11'(Y_MIN);
   localparam logic [10:0]        c_Y_INIT    = 11'(Y_INIT);
   localparam logic [10:0]        c_PIPE_W    = 11'(PIPE_W);
   localparam logic [10:0]        c_SCREEN_W  = 11'(SCREEN_W);
   localparam logic [9:0]         c_LFSR_SEED = 10'h001;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_E_SEL  = 3'd1,
      S_E_WAIT = 3'd2,
      S_MOVE   = 3'd3,
      S_D_SEL  = 3'd4,
      S_D_WAIT = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [c_IDX_W-1:0]   idx_q, idx_d;
   logic [10:0]          pos_x_q [NUM_PIPES];
   logic [10:0]          pos_y_q [NUM_PIPES];
   logic [9:0]           lfsr_q;

   logic [10:0]          w_rel_x;
   logic                 w_vis;
   logic                 w_last;

   // Unsigned 11-bit subtraction: pipes whose right edge is left of PIPE_W
   // underflow to a large value and therefore count as invisible.
   assign w_rel_x = pos_x_q[idx_q] - c_PIPE_W;
   assign w_vis   = (w_rel_x < c_SCREEN_W);
   assign w_last  = (idx_q == c_LAST);

   // ------------------------------------------------------------------------
   // State / index register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Erase and draw passes share the same walk over the
   // pipe index; only the exit state after the last pipe differs.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               state_d = S_E_SEL;
               idx_d   = '0;
            end
         end
         S_E_SEL: begin
            if (w_vis)       state_d = S_E_WAIT;
            else if (w_last) state_d = S_MOVE;
            else             idx_d   = idx_q + 1'b1;
         end
         S_E_WAIT: begin
            if (drawer_done) begin
               if (w_last) begin
                  state_d = S_MOVE;
               end else begin
                  state_d = S_E_SEL;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         S_MOVE: begin
            state_d = S_D_SEL;
            idx_d   = '0;
         end
         S_D_SEL: begin
            if (w_vis)       state_d = S_D_WAIT;
            else if (w_last) state_d = S_FIN;
            else             idx_d   = idx_q + 1'b1;
         end
         S_D_WAIT: begin
            if (drawer_done) begin
               if (w_last) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_D_SEL;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Pipe positions and gap LFSR. All pipes scroll in the single MOVE cycle;
   // a wrapping pipe takes the LFSR value present before this cycle's step.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= c_LFSR_SEED;
         for (int k = 0; k < NUM_PIPES; k++) begin
            pos_x_q[k] <= 11'(START_X + k * SPACING);
            pos_y_q[k] <= c_Y_INIT;
         end
      end else if (state_q == S_MOVE) begin
         // Fibonacci LFSR, x^10 + x^7 + 1
         lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
         for (int k = 0; k < NUM_PIPES; k++) begin
            if (pos_x_q[k] >= c_SPEED) begin
               pos_x_q[k] <= pos_x_q[k] - c_SPEED;
            end else begin
               pos_x_q[k] <= pos_x_q[k] - c_SPEED + c_WRAP_ADD;
               pos_y_q[k] <= c_Y_MIN + {4'b0000, lfsr_q[6:0]};
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign pipe_x        = pos_x_q[idx_q];
   assign pipe_y        = pos_y_q[idx_q];
   assign color         = (state_q == S_D_SEL) || (state_q == S_D_WAIT) ||
                          (state_q == S_FIN);
   assign drawer_enable = (state_q == S_E_WAIT) || (state_q == S_D_WAIT);
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_frame_sequencer
// Description : Self-checking bench for pipe_frame_sequencer. A frame-level
//               model predicts the list of drawer jobs, the scrolled
//               positions and the frame length; a second small instance
//               exercises the visibility boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_frame_sequencer;

   localparam int NP = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        drawer_done = 1'b0;
   logic        drawer_enable;
   logic [10:0] pipe_x, pipe_y;
   logic        color, busy, frame_done;

   logic        tick2;
   logic        done2;
   logic        en2, col2, busy2, fd2;
   logic [10:0] x2, y2;

   always #5 clk = ~clk;

   pipe_frame_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .drawer_done   (drawer_done),
      .drawer_enable (drawer_enable),
      .pipe_x        (pipe_x),
      .pipe_y        (pipe_y),
      .color         (color),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   // Two pipes starting just right of the visibility limit, scrolling 1 px
   pipe_frame_sequencer #(.NUM_PIPES(2), .START_X(711), .SPEED(1)) dut2 (
      .clk           (clk),
      .reset         (reset),
      .frame_tick    (tick2),
      .drawer_done   (done2),
      .drawer_enable (en2),
      .pipe_x        (x2),
      .pipe_y        (y2),
      .color         (col2),
      .busy          (busy2),
      .frame_done    (fd2)
   );

   // A drawer that finishes in the same cycle it is enabled
   assign done2 = 1'b1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Frame-level reference model
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        c;
   } job_t;

   logic [10:0] mx [NP];
   logic [10:0] my [NP];
   logic [9:0]  mlfsr;
   job_t        exp_q[$];
   job_t        obs_q[$];
   int          exp_n;
   logic [10:0] exp_x0_old, exp_y0_old, exp_x0_new, exp_y0_new;
   int          obs_busy;
   int          obs_x0_new, obs_y0_new;

   function automatic bit is_visible(input logic [10:0] x);
      logic [10:0] r;
      r = x - 11'd70;
      return (r < 11'd640);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NP; k++) begin
         mx[k] = 11'(640 + 240 * k);
         my[k] = 11'd300;
      end
      mlfsr = 10'h001;
   endtask

   task automatic plan_frame();
      job_t j;
      exp_q.delete();
      exp_x0_old = mx[0];
      exp_y0_old = my[0];
      for (int k = 0; k < NP; k++)
         if (is_visible(mx[k])) begin
            j.x = mx[k]; j.y = my[k]; j.c = 1'b0;
            exp_q.push_back(j);
         end
      for (int k = 0; k < NP; k++) begin
         if (mx[k] >= 11'd2) begin
            mx[k] = mx[k] - 11'd2;
         end else begin
            mx[k] = mx[k] - 11'd2 + 11'd720;
            my[k] = 11'd200 + {4'd0, mlfsr[6:0]};
         end
      end
      mlfsr = {mlfsr[8:0], mlfsr[9] ^ mlfsr[6]};
      exp_x0_new = mx[0];
      exp_y0_new = my[0];
      for (int k = 0; k < NP; k++)
         if (is_visible(mx[k])) begin
            j.x = mx[k]; j.y = my[k]; j.c = 1'b1;
            exp_q.push_back(j);
         end
      exp_n = exp_q.size();
   endtask

   // ---------------------------------------------------------------------
   // Drawer model: raises done after cur_lat enabled cycles
   // ---------------------------------------------------------------------
   int lat_mode = 0;
   int cur_lat  = 5;
   int lat_sum  = 0;
   int dcnt     = 0;

   always begin
      @(posedge clk);
      #2;
      if (drawer_enable) begin
         if (dcnt == 0) begin
            cur_lat = (lat_mode != 0) ? int'($urandom_range(1, 6)) : 5;
            lat_sum += cur_lat;
         end
         dcnt++;
         drawer_done = (dcnt == cur_lat);
      end else begin
         dcnt        = 0;
         drawer_done = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // One frame: tick, then compare every cycle until frame_done
   // ---------------------------------------------------------------------
   task automatic run_frame(input bit inject_fixed, input bit inject_rand);
      int   cyc, busy_cnt, en_cycles, exp_lat;
      bit   prev_en, prev_col, prev_done, first, seen_fd, stable_ok, te, td;
      job_t cur, j;
      plan_frame();
      obs_q.delete();
      lat_sum = 0;
      cyc = 0; busy_cnt = 0; en_cycles = 0; exp_lat = 0;
      prev_en = 0; prev_col = 0; prev_done = 0; first = 1;
      seen_fd = 0; stable_ok = 1; te = 0; td = 0;
      cur = '0;
      obs_x0_new = -1; obs_y0_new = -1;
      @(negedge clk);
      frame_tick = 1'b1;
      while (!seen_fd && cyc < 2000) begin
         @(negedge clk);
         frame_tick = 1'b0;
         cyc++;
         if (busy) busy_cnt++;
         if (first) begin
            chk("sel0_busy", int'(busy), 1);
            chk("sel0_x", int'(pipe_x), int'(exp_x0_old));
            chk("sel0_y", int'(pipe_y), int'(exp_y0_old));
            first = 0;
         end
         if (prev_done && prev_en)
            chk("en_after_done", int'(drawer_enable), 0);
         if (drawer_enable && !prev_en) begin
            cur.x = pipe_x; cur.y = pipe_y; cur.c = color;
            obs_q.push_back(cur);
            if (exp_q.size() == 0) begin
               chk("job_extra", obs_q.size(), exp_n);
            end else begin
               j = exp_q.pop_front();
               chk("job_x", int'(pipe_x), int'(j.x));
               chk("job_y", int'(pipe_y), int'(j.y));
               chk("job_color", int'(color), int'(j.c));
            end
            en_cycles = 0;
            stable_ok = 1;
            exp_lat   = cur_lat;
         end
         if (drawer_enable) begin
            en_cycles++;
            if (pipe_x != cur.x || pipe_y != cur.y || color != cur.c) stable_ok = 0;
         end
         if (!drawer_enable && prev_en) begin
            chk("en_length", en_cycles, exp_lat);
            chk("job_stable", int'(stable_ok), 1);
         end
         if (color && !prev_col) begin
            obs_x0_new = int'(pipe_x);
            obs_y0_new = int'(pipe_y);
            chk("dsel0_x", int'(pipe_x), int'(exp_x0_new));
            chk("dsel0_y", int'(pipe_y), int'(exp_y0_new));
         end
         if (frame_done) begin
            seen_fd = 1;
            chk("fin_color", int'(color), 1);
         end
         if (inject_fixed && drawer_enable && !color && !te) begin
            frame_tick = 1'b1; te = 1;
         end
         if (inject_fixed && drawer_enable && color && !td) begin
            frame_tick = 1'b1; td = 1;
         end
         if (inject_rand && $urandom_range(0, 7) == 0) frame_tick = 1'b1;
         prev_en   = drawer_enable;
         prev_col  = color;
         prev_done = drawer_done;
      end
      chk("frame_done_seen", int'(seen_fd), 1);
      chk("busy_cycles", busy_cnt, 2 * NP + 2 + lat_sum);
      chk("jobs_left", exp_q.size(), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         chk("idle_busy", int'(busy), 0);
         chk("idle_frame_done", int'(frame_done), 0);
      end
      obs_busy = busy_cnt;
   endtask

   // Literal expectations for the first frame after reset
   task automatic check_first_frame();
      chk("f1_jobs", obs_q.size(), 2);
      chk("f1_busy", obs_busy, 18);
      if (obs_q.size() >= 2) begin
         chk("f1_erase_x", int'(obs_q[0].x), 640);
         chk("f1_erase_y", int'(obs_q[0].y), 300);
         chk("f1_erase_c", int'(obs_q[0].c), 0);
         chk("f1_draw_x",  int'(obs_q[1].x), 638);
         chk("f1_draw_y",  int'(obs_q[1].y), 300);
         chk("f1_draw_c",  int'(obs_q[1].c), 1);
      end
   endtask

   // Frame on the boundary instance
   task automatic run_frame2(output int n_en, output int first_x,
                             output int first_c, output int last_x,
                             output int last_c, output int n_fd);
      n_en = 0; first_x = -1; first_c = -1; last_x = -1; last_c = -1; n_fd = 0;
      @(negedge clk);
      tick2 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         tick2 = 1'b0;
         if (en2) begin
            if (n_en == 0) begin
               first_x = int'(x2); first_c = int'(col2);
            end
            n_en++;
            last_x = int'(x2); last_c = int'(col2);
         end
         if (fd2) n_fd++;
      end
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int  n_en, fx, fc, lx, lc, nfd;
      bit  found;
      reset      = 1'b1;
      frame_tick = 1'b0;
      tick2      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_busy", int'(busy), 0);
         chk("rst_enable", int'(drawer_enable), 0);
         chk("rst_frame_done", int'(frame_done), 0);
         chk("rst_x", int'(pipe_x), 640);
         chk("rst_y", int'(pipe_y), 300);
         chk("rst_color", int'(color), 0);
      end

      // First frame, fixed drawer latency
      lat_mode = 0;
      run_frame(1'b0, 1'b0);
      check_first_frame();

      // Ticks during erase-wait and draw-wait are dropped
      run_frame(1'b1, 1'b0);

      // Random frames until pipe 0 reaches the left edge, then the wrap
      lat_mode = 1;
      while (mx[0] != 11'd0 && bad < 50) run_frame(1'b0, 1'b1);
      run_frame(1'b0, 1'b1);
      chk("wrap_x0", obs_x0_new, 718);
      chk("wrap_y0", obs_y0_new, int'(my[0]));

      // Visibility boundary on the second instance
      run_frame2(n_en, fx, fc, lx, lc, nfd);
      chk("b710_enables", n_en, 0);
      chk("b710_frame_done", nfd, 1);
      run_frame2(n_en, fx, fc, lx, lc, nfd);
      chk("b709_enables", n_en, 1);
      chk("b709_x", lx, 709);
      chk("b709_color", lc, 1);
      run_frame2(n_en, fx, fc, lx, lc, nfd);
      chk("b708_enables", n_en, 2);
      chk("b708_erase_x", fx, 709);
      chk("b708_erase_c", fc, 0);
      chk("b708_draw_x", lx, 708);

      // Reset while waiting on the drawer in the draw pass
      lat_mode = 0;
      @(negedge clk);
      frame_tick = 1'b1;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (drawer_enable && color) found = 1;
      end
      chk("reach_draw_wait", int'(found), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_enable", int'(drawer_enable), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_x", int'(pipe_x), 640);
      chk("mid_rst_y", int'(pipe_y), 300);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      run_frame(1'b0, 1'b0);
      check_first_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
